// File: rtl/sram_word_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_word_model: cycle-accurate model of the 32-bit external word SRAM.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_word_model #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic                  sram_we_en
);

  localparam int c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_in_range;
  logic [c_idx_w-1:0]    w_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_drive;

  // Range check is done one bit wider so MEM_DEPTH == 2**ADDR_WIDTH still fits.
  assign w_in_range = ({1'b0, sram_addr} < c_depth);
  assign w_idx      = sram_addr[c_idx_w-1:0];
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

  // The bus is only driven on a read outside reset, so it turns around
  // combinationally with sram_we_en and never fights the controller.
  assign w_drive = !rst && sram_we_en;
  assign sram_dq = w_drive ? w_rd_data : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!sram_we_en && w_in_range) begin
      r_mem[w_idx] <= sram_dq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_word_model.sv
`default_nettype none
// Scoreboard bench for sram_word_model: directed reads/writes plus a slow-SRAM
// store/load sequence driven from a faster CPU clock.
module tb_sram_word_model;

  logic        clk = 1'b0;
  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sram_addr = '0;
  logic        sram_we_en = 1'b1;
  logic        tb_drive = 1'b0;
  logic [31:0] tb_data = '0;
  // Weak pull-up makes a released bus observable as all ones.
  tri1  [31:0] sram_dq;

  assign sram_dq = tb_drive ? tb_data : 32'hzzzz_zzzz;

  always #40 clk = ~clk;
  always #20 cpu_clk = ~cpu_clk;

  sram_word_model #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(18),
    .MEM_DEPTH (65536)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_en(sram_we_en)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  localparam logic [31:0] c_released = 32'hFFFF_FFFF;

  exp_t        exp_q[$];
  event        sample_req;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cpu_reg [5];
  logic [31:0] cpu_val [5] = '{32'h0102_0304, 32'hA5A5_5A5A, 32'h8000_0001,
                                32'h7FFF_FFFF, 32'h0F0F_F0F0};

  // Monitor: compares the bus against the oldest expected value on each sample.
  initial begin
    exp_t item;
    forever begin
      @(sample_req);
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: got %h, no expected value queued", sram_dq);
      end else begin
        item = exp_q.pop_front();
        if (sram_dq !== item.val) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", item.name, sram_dq, item.val);
        end
      end
    end
  end

  task automatic expect_bus(input string name, input logic [31:0] val);
    exp_q.push_back('{name: name, val: val});
    -> sample_req;
    #5;
  endtask

  task automatic sram_write(input logic [17:0] addr, input logic [31:0] data);
    @(negedge clk);
    sram_addr  = addr;
    tb_data    = data;
    tb_drive   = 1'b1;
    sram_we_en = 1'b0;
  endtask

  task automatic sram_read(input logic [17:0] addr, input logic [31:0] val,
                           input string name, input bit wait_edge);
    if (wait_edge) @(negedge clk);
    tb_drive   = 1'b0;
    sram_we_en = 1'b1;
    sram_addr  = addr;
    expect_bus(name, val);
  endtask

  task automatic cpu_store(input logic [17:0] addr, input logic [31:0] data);
    @(posedge cpu_clk);
    #1;
    sram_addr  = addr;
    tb_data    = data;
    tb_drive   = 1'b1;
    sram_we_en = 1'b0;
    repeat (3) @(posedge cpu_clk);
  endtask

  task automatic cpu_load(input logic [17:0] addr, input int k, input logic [31:0] val);
    @(posedge cpu_clk);
    #1;
    tb_drive   = 1'b0;
    sram_we_en = 1'b1;
    sram_addr  = addr;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_reg[k] = sram_dq;
    expect_bus($sformatf("cpu_load_%0d", k), val);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two SRAM edges; the bus must stay released meanwhile.
    rst = 1'b1;
    @(negedge clk);
    sram_we_en = 1'b1;
    sram_addr  = 18'h00010;
    expect_bus("reset_bus_released", c_released);
    @(negedge clk);
    rst = 1'b0;
    sram_read(18'h00010, 32'h0, "reset_addr_0x10", 1'b0);
    sram_read(18'h0FFFF, 32'h0, "reset_addr_0xffff", 1'b0);

    sram_write(18'h00004, 32'hDEAD_BEEF);
    sram_read(18'h00004, 32'hDEAD_BEEF, "write_read_0x4", 1'b1);
    sram_read(18'h00005, 32'h0, "neighbour_0x5", 1'b0);

    sram_write(18'h00100, 32'h1111_1111);
    sram_write(18'h00100, 32'h2222_2222);
    sram_read(18'h00100, 32'h2222_2222, "overwrite_0x100", 1'b1);

    sram_write(18'h00000, 32'h5A5A_5A5A);
    sram_write(18'h10000, 32'hCAFE_F00D);
    sram_read(18'h10000, 32'h0, "oor_read_0x10000", 1'b1);
    sram_read(18'h00000, 32'h5A5A_5A5A, "oor_alias_0x0", 1'b0);
    sram_read(18'h3FFFF, 32'h0, "oor_read_0x3ffff", 1'b0);

    @(negedge clk);
    tb_drive   = 1'b0;
    sram_we_en = 1'b0;
    sram_addr  = 18'h00004;
    expect_bus("write_bus_released", c_released);

    sram_write(18'h00020, 32'hAAAA_5555);
    sram_read(18'h00020, 32'hAAAA_5555, "pre_reset_0x20", 1'b1);

    // Write coincides with reset: it must be dropped and the bus released.
    sram_write(18'h00020, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    tb_drive   = 1'b0;
    sram_we_en = 1'b1;
    expect_bus("reset_read_released", c_released);
    @(negedge clk);
    rst = 1'b0;
    sram_read(18'h00020, 32'h0, "reset_write_dropped", 1'b0);
    sram_read(18'h00004, 32'h0, "reset_cleared_0x4", 1'b0);

    for (int k = 0; k < 5; k++) cpu_store(18'h00200 + 18'(k), cpu_val[k]);
    for (int k = 0; k < 5; k++) cpu_load(18'h00200 + 18'(k), k, cpu_val[k]);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (cpu_reg[k] !== cpu_val[k]) begin
        n_fail++;
        $display("FAIL cpu_reg_%0d: got %h expected %h", k, cpu_reg[k], cpu_val[k]);
      end
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
